// File: rtl/uop_regroup_if.sv
// Commit-side bundle for uop_regroup: committed micro-op stream in, regrouped
// ISA-instruction records out through a ready/valid FIFO head.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

interface uop_regroup_if;
    logic                  iw_valid;
    logic [`SIZE_ADDR-1:0] iw_pc;
    logic [`SIZE_DATA-1:0] iw_instr;
    logic                  iw_flush;
    logic                  iw_ready;
    logic                  ow_valid;
    logic [`SIZE_ADDR-1:0] ow_pc;
    logic [3:0]            ow_kind;
    logic [2:0]            ow_uops;
    logic [`SIZE_DATA-1:0] ow_head;
    logic [`SIZE_DATA-1:0] ow_tail;
    logic                  ow_ovf;

    modport master (
        output iw_valid, iw_pc, iw_instr, iw_flush, iw_ready,
        input  ow_valid, ow_pc, ow_kind, ow_uops, ow_head, ow_tail, ow_ovf
    );
    modport slave (
        input  iw_valid, iw_pc, iw_instr, iw_flush, iw_ready,
        output ow_valid, ow_pc, ow_kind, ow_uops, ow_head, ow_tail, ow_ovf
    );
endinterface

// File: rtl/uop_regroup.sv
// Collapses committed micro-op expansions (call/ret/push/pop) back into one record
// per macro. Word layout: [31:24] opcode, [23:20] rA/ARt, [19:16] rB/ARs, [15:0] imm.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module uop_regroup #(
    parameter int FIFO_DEPTH = 4
) (
    input logic          iw_clk,
    input logic          iw_rst,
    uop_regroup_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] OP_SRSUBSI = 8'h10, OP_SRADDSI = 8'h11, OP_SUBASI = 8'h12,
                           OP_ADDASI  = 8'h13, OP_SRSTSO  = 8'h14, OP_SRMOVUR = 8'h15,
                           OP_JCCUR   = 8'h16, OP_JCCUI   = 8'h17, OP_BCCSR   = 8'h18,
                           OP_BALSO   = 8'h19, OP_SRLDSO  = 8'h1A, OP_SRJCCSO = 8'h1B,
                           OP_STUR    = 8'h1C, OP_STASO   = 8'h1D, OP_LDSO    = 8'h1E,
                           OP_LDASO   = 8'h1F;
    localparam logic [3:0] SR_SSP = 4'd1, SR_LR = 4'd2, SR_PC = 4'd3;
    localparam logic [2:0] G_CALL = 3'd0, G_RET = 3'd1, G_PUSH = 3'd2, G_PUSHA = 3'd3,
                           G_POP = 3'd4, G_POPA = 3'd5;
    localparam logic [3:0] K_PLAIN = 4'd0, K_PARTIAL = 4'd15;

    typedef struct packed {
        logic [`SIZE_ADDR-1:0] pc;
        logic [3:0]            kind;
        logic [2:0]            uops;
        logic [`SIZE_DATA-1:0] head;
        logic [`SIZE_DATA-1:0] tail;
    } rec_t;

    typedef enum logic {IDLE, PEND} state_t;

    // Returns {is_head, group type}.
    function automatic logic [3:0] decode_head(input logic [`SIZE_DATA-1:0] w);
        logic [3:0] r;
        r = 4'd0;
        case (w[31:24])
            OP_SRSUBSI: if (w[23:20] == SR_SSP && w[13:0] == 14'd2) r = {1'b1, G_CALL};
            OP_SRADDSI: if (w[23:20] == SR_SSP && w[13:0] == 14'd2) r = {1'b1, G_RET};
            OP_SUBASI: begin
                if (w[11:0] == 12'd1)      r = {1'b1, G_PUSH};
                else if (w[11:0] == 12'd2) r = {1'b1, G_PUSHA};
            end
            OP_ADDASI: begin
                if (w[11:0] == 12'd1)      r = {1'b1, G_POP};
                else if (w[11:0] == 12'd2) r = {1'b1, G_POPA};
            end
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic uop_matches(input logic [2:0] gtype, input logic [2:0] idx,
                                         input logic [`SIZE_DATA-1:0] head,
                                         input logic [`SIZE_DATA-1:0] w);
        logic m;
        m = 1'b0;
        case (gtype)
            G_CALL: case (idx)
                3'd1: m = w[31:24] == OP_SRSTSO && w[23:20] == SR_SSP && w[19:16] == SR_LR
                          && w[13:0] == 14'd0;
                3'd2: m = w[31:24] == OP_SRMOVUR && w[23:20] == SR_LR && w[19:16] == SR_PC;
                3'd3: m = w[31:24] inside {OP_JCCUR, OP_JCCUI, OP_BCCSR, OP_BALSO};
                default: m = 1'b0;
            endcase
            G_RET: case (idx)
                3'd1: m = w[31:24] == OP_SRLDSO && w[23:20] == SR_LR && w[19:16] == SR_SSP
                          && w[13:0] == 14'h3FFE;
                3'd2: m = w[31:24] == OP_SRJCCSO && w[23:20] == SR_LR;
                default: m = 1'b0;
            endcase
            G_PUSH:  m = w[31:24] == OP_STUR  && w[23:20] == head[23:20];
            G_PUSHA: m = w[31:24] == OP_STASO && w[23:20] == head[23:20];
            G_POP:   m = w[31:24] == OP_LDSO  && w[19:16] == head[23:20];
            G_POPA:  m = w[31:24] == OP_LDASO && w[19:16] == head[23:20];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] final_kind(input logic [2:0] gtype,
                                              input logic [`SIZE_DATA-1:0] w);
        logic [3:0] k;
        case (gtype)
            G_CALL: case (w[31:24])
                OP_JCCUR: k = 4'd1;
                OP_JCCUI: k = 4'd2;
                OP_BCCSR: k = 4'd3;
                default:  k = 4'd4;
            endcase
            G_RET:   k = 4'd5;
            G_PUSH:  k = 4'd6;
            G_PUSHA: k = 4'd7;
            G_POP:   k = 4'd8;
            default: k = 4'd9;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] group_len(input logic [2:0] gtype);
        case (gtype)
            G_CALL:  return 3'd4;
            G_RET:   return 3'd3;
            default: return 3'd2;
        endcase
    endfunction

    state_t                state, state_nxt;
    logic [`SIZE_ADDR-1:0] h_pc;
    logic [`SIZE_DATA-1:0] h_head, h_tail;
    logic [2:0]            h_type, h_cnt;
    logic [3:0]            cur_head;
    logic                  load_grp, adv_grp, push0, push1;
    rec_t                  rec0, rec1, plain_rec, held_rec, done_rec;

    rec_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fcnt, free_slots;
    logic                  fifo_pop, keep0, keep1, drop, ovf;
    rec_t                  head_rec;

    assign cur_head  = decode_head(bus.iw_instr);
    assign plain_rec = '{pc: bus.iw_pc, kind: K_PLAIN, uops: 3'd1,
                         head: bus.iw_instr, tail: bus.iw_instr};
    assign held_rec  = '{pc: h_pc, kind: (h_cnt == 3'd1) ? K_PLAIN : K_PARTIAL,
                         uops: h_cnt, head: h_head, tail: h_tail};
    assign done_rec  = '{pc: h_pc, kind: final_kind(h_type, bus.iw_instr),
                         uops: group_len(h_type), head: h_head, tail: bus.iw_instr};

    always_comb begin
        state_nxt = state;
        load_grp  = 1'b0;
        adv_grp   = 1'b0;
        push0     = 1'b0;
        push1     = 1'b0;
        rec0      = plain_rec;
        rec1      = plain_rec;
        case (state)
            IDLE: if (!bus.iw_flush && bus.iw_valid) begin
                if (cur_head[3]) begin
                    load_grp  = 1'b1;
                    state_nxt = PEND;
                end else begin
                    push0 = 1'b1;
                end
            end
            PEND: if (bus.iw_flush) begin
                push0     = 1'b1;
                rec0      = held_rec;
                state_nxt = IDLE;
            end else if (bus.iw_valid) begin
                if (bus.iw_pc == h_pc && uop_matches(h_type, h_cnt, h_head, bus.iw_instr)) begin
                    if (h_cnt + 3'd1 == group_len(h_type)) begin
                        push0     = 1'b1;
                        rec0      = done_rec;
                        state_nxt = IDLE;
                    end else begin
                        adv_grp = 1'b1;
                    end
                end else begin
                    // Held group goes out first; the current op is then treated as in IDLE.
                    push0 = 1'b1;
                    rec0  = held_rec;
                    if (cur_head[3]) begin
                        load_grp  = 1'b1;
                        state_nxt = PEND;
                    end else begin
                        push1     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Space is judged after this cycle's pop; the second record loses when only one slot is free.
    assign fifo_pop   = (fcnt != '0) && bus.iw_ready;
    assign free_slots = CNT_W'(FIFO_DEPTH) - fcnt + CNT_W'(fifo_pop);
    assign keep0      = push0 && (free_slots != '0);
    assign keep1      = push1 && (free_slots >= CNT_W'(2));
    assign drop       = (push0 && !keep0) || (push1 && !keep1);

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state  <= IDLE;
            h_cnt  <= 3'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_grp)     h_cnt <= 3'd1;
            else if (adv_grp) h_cnt <= h_cnt + 3'd1;
            wr_ptr <= wr_ptr + PTR_W'(keep0) + PTR_W'(keep1);
            rd_ptr <= rd_ptr + PTR_W'(fifo_pop);
            fcnt   <= fcnt + CNT_W'(keep0) + CNT_W'(keep1) - CNT_W'(fifo_pop);
            if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (load_grp) begin
            h_pc   <= bus.iw_pc;
            h_head <= bus.iw_instr;
            h_tail <= bus.iw_instr;
            h_type <= cur_head[2:0];
        end else if (adv_grp) begin
            h_tail <= bus.iw_instr;
        end
        if (keep0) mem[wr_ptr] <= rec0;
        if (keep1) mem[wr_ptr + PTR_W'(1)] <= rec1;
    end

    assign head_rec     = mem[rd_ptr];
    assign bus.ow_valid = (fcnt != '0);
    assign bus.ow_pc    = bus.ow_valid ? head_rec.pc   : '0;
    assign bus.ow_kind  = bus.ow_valid ? head_rec.kind : '0;
    assign bus.ow_uops  = bus.ow_valid ? head_rec.uops : '0;
    assign bus.ow_head  = bus.ow_valid ? head_rec.head : '0;
    assign bus.ow_tail  = bus.ow_valid ? head_rec.tail : '0;
    assign bus.ow_ovf   = ovf;
endmodule

// File: tb/tb_uop_regroup.sv
// Scoreboard bench for uop_regroup: expected records are queued as micro-ops are
// driven and compared whenever the record FIFO hands one over.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_uop_regroup;
    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;

    uop_regroup_if bus();

    uop_regroup #(.FIFO_DEPTH(4)) dut (
        .iw_clk(iw_clk),
        .iw_rst(iw_rst),
        .bus   (bus)
    );

    always #5 iw_clk = ~iw_clk;

    typedef struct {
        logic [`SIZE_ADDR-1:0] pc;
        logic [3:0]            kind;
        logic [2:0]            uops;
        logic [`SIZE_DATA-1:0] head;
        logic [`SIZE_DATA-1:0] tail;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [3:0] SSP = 4'd1, LR = 4'd2, PCR = 4'd3;

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rec(input logic [15:0] pc, input logic [3:0] kind,
                              input logic [2:0] uops, input logic [31:0] head,
                              input logic [31:0] tail);
        exp_t e;
        e.pc = pc; e.kind = kind; e.uops = uops; e.head = head; e.tail = tail;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic f, input logic [15:0] pc,
                         input logic [31:0] w, input logic rdy);
        @(posedge iw_clk);
        #1;
        bus.iw_valid = v;
        bus.iw_flush = f;
        bus.iw_pc    = pc;
        bus.iw_instr = w;
        bus.iw_ready = rdy;
    endtask

    task automatic wait_drain(input string tag);
        int i = 0;
        while (sb.size() != 0 && i < 100) begin
            @(posedge iw_clk);
            i++;
        end
        @(negedge iw_clk);
        check_eq(tag, 64'(sb.size()), 64'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        #2;
        iw_rst       = 1'b1;
        bus.iw_valid = 1'b0;
        bus.iw_flush = 1'b0;
        sb.delete();
        #1;
        check_eq({tag, "_valid"}, 64'(bus.ow_valid), 64'd0);
        check_eq({tag, "_ovf"},   64'(bus.ow_ovf),   64'd0);
        repeat (2) @(posedge iw_clk);
        #3;
        iw_rst = 1'b0;
    endtask

    always @(negedge iw_clk) begin : monitor
        exp_t e;
        if (!iw_rst && bus.ow_valid && bus.iw_ready) begin
            if (sb.size() == 0) begin
                check_eq("extra_rec", 64'(bus.ow_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("rec_pc",   64'(bus.ow_pc),   64'(e.pc));
                check_eq("rec_kind", 64'(bus.ow_kind), 64'(e.kind));
                check_eq("rec_uops", 64'(bus.ow_uops), 64'(e.uops));
                check_eq("rec_head", 64'(bus.ow_head), 64'(e.head));
                check_eq("rec_tail", 64'(bus.ow_tail), 64'(e.tail));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] addur, call_hd, srst, srmov, jccui, balso;
        logic [31:0] ret_hd, srld, srjcc, push_hd, stur, stur2, popa_hd, ldaso;
        logic [31:0] pusha_hd, staso, push3_hd, stur3;
        logic [31:0] jsr_seq [4];

        addur    = mk(8'h01, 4'd5, 4'd6, 16'h0000);
        call_hd  = mk(8'h10, SSP, 4'd0, 16'd2);
        srst     = mk(8'h14, SSP, LR, 16'd0);
        srmov    = mk(8'h15, LR, PCR, 16'd0);
        jccui    = mk(8'h17, 4'd0, 4'd0, 16'h0040);
        balso    = mk(8'h19, 4'd0, 4'd0, 16'h0100);
        ret_hd   = mk(8'h11, SSP, 4'd0, 16'd2);
        srld     = mk(8'h1A, LR, SSP, 16'h3FFE);
        srjcc    = mk(8'h1B, LR, 4'd0, 16'd0);
        push_hd  = mk(8'h12, 4'd1, 4'd0, 16'd1);
        stur     = mk(8'h1C, 4'd1, 4'd7, 16'd0);
        stur2    = mk(8'h1C, 4'd2, 4'd7, 16'd0);
        popa_hd  = mk(8'h13, 4'd4, 4'd0, 16'd2);
        ldaso    = mk(8'h1F, 4'd9, 4'd4, 16'd0);
        pusha_hd = mk(8'h12, 4'd2, 4'd0, 16'd2);
        staso    = mk(8'h1D, 4'd2, 4'd8, 16'd0);
        push3_hd = mk(8'h12, 4'd3, 4'd0, 16'd1);
        stur3    = mk(8'h1C, 4'd3, 4'd6, 16'd0);
        jsr_seq  = '{call_hd, srst, srmov, jccui};

        bus.iw_valid = 1'b0;
        bus.iw_flush = 1'b0;
        bus.iw_pc    = '0;
        bus.iw_instr = '0;
        bus.iw_ready = 1'b1;
        repeat (3) @(posedge iw_clk);
        #2;
        check_eq("rst_valid", 64'(bus.ow_valid), 64'd0);
        check_eq("rst_pc",    64'(bus.ow_pc),    64'd0);
        check_eq("rst_kind",  64'(bus.ow_kind),  64'd0);
        check_eq("rst_uops",  64'(bus.ow_uops),  64'd0);
        check_eq("rst_head",  64'(bus.ow_head),  64'd0);
        check_eq("rst_tail",  64'(bus.ow_tail),  64'd0);
        check_eq("rst_ovf",   64'(bus.ow_ovf),   64'd0);
        iw_rst = 1'b0;

        // Plain instruction, one-cycle latency
        expect_rec(16'h100, 4'd0, 3'd1, addur, addur);
        drive(1, 0, 16'h100, addur, 1);
        drive(0, 0, 16'h0, 32'h0, 1);
        @(negedge iw_clk);
        check_eq("plain_lat", 64'(bus.ow_valid), 64'd1);

        // JSRui with idle gaps: nothing visible until the fourth micro-op
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expect_rec(16'h200, 4'd2, 3'd4, call_hd, jccui);
            drive(1, 0, 16'h200, jsr_seq[i], 1);
            drive(0, 0, 16'h0, 32'h0, 1);
            @(negedge iw_clk);
            check_eq($sformatf("jsr_gap%0d", i), 64'(bus.ow_valid), (i == 3) ? 64'd1 : 64'd0);
        end

        // Back-to-back macros: RET, BSRso, POPA, PUSHA
        expect_rec(16'h210, 4'd5, 3'd3, ret_hd, srjcc);
        expect_rec(16'h220, 4'd4, 3'd4, call_hd, balso);
        expect_rec(16'h230, 4'd9, 3'd2, popa_hd, ldaso);
        expect_rec(16'h240, 4'd7, 3'd2, pusha_hd, staso);
        drive(1, 0, 16'h210, ret_hd, 1);
        drive(1, 0, 16'h210, srld, 1);
        drive(1, 0, 16'h210, srjcc, 1);
        drive(1, 0, 16'h220, call_hd, 1);
        drive(1, 0, 16'h220, srst, 1);
        drive(1, 0, 16'h220, srmov, 1);
        drive(1, 0, 16'h220, balso, 1);
        drive(1, 0, 16'h230, popa_hd, 1);
        drive(1, 0, 16'h230, ldaso, 1);
        drive(1, 0, 16'h240, pusha_hd, 1);
        drive(1, 0, 16'h240, staso, 1);

        // Mismatch after a single head: two PLAIN records in one cycle
        expect_rec(16'h300, 4'd0, 3'd1, push_hd, push_hd);
        expect_rec(16'h302, 4'd0, 3'd1, addur, addur);
        drive(1, 0, 16'h300, push_hd, 1);
        drive(1, 0, 16'h302, addur, 1);

        // Wrong ARt on the store breaks the PUSH
        expect_rec(16'h310, 4'd0, 3'd1, push_hd, push_hd);
        expect_rec(16'h310, 4'd0, 3'd1, stur2, stur2);
        drive(1, 0, 16'h310, push_hd, 1);
        drive(1, 0, 16'h310, stur2, 1);

        // Right store but different PC also breaks the group
        expect_rec(16'h320, 4'd0, 3'd1, push_hd, push_hd);
        expect_rec(16'h322, 4'd0, 3'd1, stur, stur);
        drive(1, 0, 16'h320, push_hd, 1);
        drive(1, 0, 16'h322, stur, 1);

        // Call broken after two matched micro-ops -> PARTIAL, then the intruder as PLAIN
        expect_rec(16'h330, 4'd15, 3'd2, call_hd, srst);
        expect_rec(16'h332, 4'd0, 3'd1, addur, addur);
        drive(1, 0, 16'h330, call_hd, 1);
        drive(1, 0, 16'h330, srst, 1);
        drive(1, 0, 16'h332, addur, 1);
        drive(0, 0, 16'h0, 32'h0, 1);
        wait_drain("drain_a");

        // Flush after two RET micro-ops; the flush-cycle op is ignored
        expect_rec(16'h400, 4'd15, 3'd2, ret_hd, srld);
        drive(1, 0, 16'h400, ret_hd, 1);
        drive(1, 0, 16'h400, srld, 1);
        drive(1, 1, 16'h400, addur, 1);
        drive(0, 0, 16'h0, 32'h0, 1);
        @(negedge iw_clk);
        check_eq("flush_rec", 64'(bus.ow_valid), 64'd1);
        drive(0, 0, 16'h0, 32'h0, 1);
        @(negedge iw_clk);
        check_eq("flush_drop", 64'(bus.ow_valid), 64'd0);

        // Back in IDLE: a clean PUSH, then a flush with only the head held
        expect_rec(16'h410, 4'd6, 3'd2, push3_hd, stur3);
        expect_rec(16'h420, 4'd0, 3'd1, call_hd, call_hd);
        drive(1, 0, 16'h410, push3_hd, 1);
        drive(1, 0, 16'h410, stur3, 1);
        drive(1, 0, 16'h420, call_hd, 1);
        drive(0, 1, 16'h0, 32'h0, 1);
        drive(0, 0, 16'h0, 32'h0, 1);
        wait_drain("drain_b");

        // Overflow: DEPTH+1 plains with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_rec(16'h500 + 16'(2 * i), 4'd0, 3'd1,
                                  mk(8'h01, 4'(i), 4'd0, 16'd0), mk(8'h01, 4'(i), 4'd0, 16'd0));
            drive(1, 0, 16'h500 + 16'(2 * i), mk(8'h01, 4'(i), 4'd0, 16'd0), 0);
        end
        drive(0, 0, 16'h0, 32'h0, 0);
        @(negedge iw_clk);
        check_eq("ovf_set",   64'(bus.ow_ovf),  64'd1);
        check_eq("ovf_head",  64'(bus.ow_pc),   64'h500);
        drive(0, 0, 16'h0, 32'h0, 1);
        wait_drain("drain_ovf");
        check_eq("ovf_sticky", 64'(bus.ow_ovf),   64'd1);
        check_eq("ovf_empty",  64'(bus.ow_valid), 64'd0);

        pulse_reset("rst1");

        // Full FIFO, pop and double push in the same cycle: first kept, second dropped
        for (int i = 0; i < 4; i++) begin
            expect_rec(16'h600 + 16'(2 * i), 4'd0, 3'd1, addur, addur);
            drive(1, 0, 16'h600 + 16'(2 * i), addur, 0);
        end
        drive(1, 0, 16'h700, push_hd, 0);
        @(negedge iw_clk);
        check_eq("ovf_pre", 64'(bus.ow_ovf), 64'd0);
        expect_rec(16'h700, 4'd0, 3'd1, push_hd, push_hd);
        drive(1, 0, 16'h702, addur, 1);
        drive(0, 0, 16'h0, 32'h0, 1);
        @(negedge iw_clk);
        check_eq("ovf_dual", 64'(bus.ow_ovf), 64'd1);
        wait_drain("drain_dual");

        // Reset mid-group with a record waiting: both are discarded
        drive(1, 0, 16'h800, addur, 0);
        drive(1, 0, 16'h810, call_hd, 0);
        drive(1, 0, 16'h810, srst, 0);
        pulse_reset("rst2");
        expect_rec(16'h810, 4'd0, 3'd1, srmov, srmov);
        drive(1, 0, 16'h810, srmov, 1);
        drive(0, 0, 16'h0, 32'h0, 1);
        wait_drain("drain_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/uop_regroup.md
# uop_regroup

Commit-side companion to the translate stage. It watches the stream of committed micro-ops and regroups them into architectural (ISA) instructions. Known expansion signatures (call, return, push, pop) are collapsed back into one record per macro. The block sits after writeback and feeds trace/debug and retire counters through a small ready/valid record FIFO.

## Interface
Parameters:
- FIFO_DEPTH, 4: record FIFO entries; power of two, ≥2.

Ports:
- iw_clk  in  1  clock. Reset iw_rst, asynchronous, active-high; clock iw_clk.
- iw_rst  in  1  asynchronous active-high reset.
- iw_valid  in  1  one micro-op commits this cycle. There is no backpressure on this input.
- iw_pc  in  `SIZE_ADDR  PC of the committing micro-op; every micro-op of a macro carries the macro's PC.
- iw_instr  in  `SIZE_DATA  committed micro-op word.
- iw_flush  in  1  pipeline flush; aborts any pending group.
- ow_valid  out  1  FIFO head record valid.
- iw_ready  in  1  consumer accepts the head record when ow_valid && iw_ready.
- ow_pc  out  `SIZE_ADDR  macro PC.
- ow_kind  out  4  0 PLAIN, 1 JSRur, 2 JSRui, 3 BSRsr, 4 BSRso, 5 RET, 6 PUSH, 7 PUSHA, 8 POP, 9 POPA, 15 PARTIAL.
- ow_uops  out  3  number of micro-ops in the record, 1..4.
- ow_head  out  `SIZE_DATA  first micro-op of the group.
- ow_tail  out  `SIZE_DATA  last micro-op of the group.
- ow_ovf  out  1  sticky: a record was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Head micro-ops are the only words that can start a group:
  - SRSUBsi with SR=SSP, imm14=2: call, expected length 4.
  - SRADDsi with SR=SSP, imm14=2: RET, expected length 3.
  - SUBAsi with imm12 of 1 or 2: PUSH or PUSHA, expected length 2.
  - ADDAsi with imm12 of 1 or 2: POP or POPA, expected length 2.
- Expected micro-op at each later index:
  - Call: SRSTso(SSP,LR,0), then SRMOVur(LR,PC), then one of JCCur, JCCui, BCCsr, BALso. That last opcode selects kind 1, 2, 3 or 4.
  - RET: SRLDso(LR,SSP,-2), then SRJCCso(LR).
  - PUSH: STur with ARt equal to the head's ARt.
  - PUSHA: STAso with ARt equal to the head's ARt.
  - POP: LDso with ARs equal to the head's ARt.
  - POPA: LDAso with ARs equal to the head's ARt.
- State IDLE. On a valid micro-op:
  - Head: latch pc, head word and expected length; count=1; go to PEND. No record is pushed.
  - Anything else: push a PLAIN record with uops=1 and head=tail=instr.
- State PEND. On a valid micro-op:
  - If iw_pc equals the held PC and iw_instr matches the expected micro-op at index count: count++.
  - If count then reaches the expected length: push the classified record with uops=length and tail=instr, and go to IDLE.
  - Mismatch: push the held group as PLAIN when count==1, or as PARTIAL when count>1, with tail set to the last matched micro-op. Then handle the current micro-op exactly as IDLE would, in the same cycle. This can produce 2 pushes in one cycle; the held group is pushed first.
- A cycle with iw_valid=0 leaves state unchanged. There is no timeout.
- iw_flush, checked before iw_valid:
  - In PEND: push the held group as PARTIAL (PLAIN if count==1) and go to IDLE.
  - The micro-op presented in a flush cycle is ignored.
  - The FIFO is not cleared.
- FIFO: up to 2 pushes and 1 pop per cycle.
  - Free space is evaluated after this cycle's pop.
  - If there is room for only one record, the first record is kept and the second is dropped.
  - Every dropped record sets ow_ovf.

## Timing
- Reset: state IDLE, FIFO empty, and every output equal to 0 (ow_valid, ow_pc, ow_kind, ow_uops, ow_head, ow_tail, ow_ovf).
- A record pushed in cycle N is visible on ow_* in N+1 if the FIFO was empty.
- PLAIN latency: 1 cycle after its commit.
- Macro latency: 1 cycle after its last micro-op commits.
- Outputs are registered and FIFO-driven. ow_* hold stable while ow_valid && !iw_ready.
- Simultaneous pop and double push at full: one slot is freed and one record is kept. The second is dropped and ow_ovf goes to 1 in the next cycle.
- Asynchronous reset mid-group discards the group and the FIFO contents.

## Test plan
- PLAIN: commit ADDur at PC 0x100 with iw_ready=1 -> next cycle ow_valid=1, kind 0, uops 1, pc 0x100.
- JSRui: commit the 4 expanded micro-ops at PC 0x200, consecutive or with gaps of iw_valid=0 -> exactly one record: kind 2, uops 4, tail opcode JCCui. No record before the 4th micro-op.
- Mismatch with double push: commit SUBAsi AR1,1 at PC 0x300, then ADDur at 0x302 -> two records in order: PLAIN 0x300, then PLAIN 0x302.
- PUSH field check: commit SUBAsi AR1,1 then STur AR2 at the same PC -> PLAIN for the SUBAsi. The STur becomes its own PLAIN record.
- Flush in PEND: after 2 RET micro-ops at 0x400, assert iw_flush -> kind 15, uops 2, state IDLE. A micro-op committed in the flush cycle produces no record.
- Overflow: iw_ready=0 and FIFO_DEPTH+1 PLAIN commits -> FIFO_DEPTH records retained in order and ow_ovf=1. ow_ovf stays 1 after draining.
